// File: rtl/md_sched.sv
// Issue controller for the HI/LO multiply/divide unit: decodes E-stage mult/div class requests
// and stalls the pipeline while the unit is busy. Optional counters under MD_SCHED_PERF_EN.
module md_sched #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        md_start,
  output logic [1:0]  md_mode,
  output logic        md_we,
  output logic        md_a1,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        rd_hilo,
  output logic        req_accept,
  output logic        stall,
  output logic        busy
`ifdef MD_SCHED_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [3:0] MultLat = 4'(MULT_LAT);
  localparam logic [3:0] DivLat  = 4'(DIV_LAT);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       go;

  // Strobes must read 0 while reset is held, so clr also masks the request.
  assign go = req_valid & ~flush & ~clr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (go && !req_op[2]) begin
          state_d = StRun;
          cnt_d   = req_op[1] ? DivLat : MultLat;
        end
      end
      StRun: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    md_start   = 1'b0;
    md_we      = 1'b0;
    md_a1      = 1'b0;
    rd_hilo    = 1'b0;
    req_accept = 1'b0;
    stall      = 1'b0;
    if (go) begin
      if (state_q == StRun) begin
        stall = 1'b1;
      end else begin
        req_accept = 1'b1;
        unique case (req_op[2:1])
          2'b00, 2'b01: md_start = 1'b1;
          2'b10: begin
            md_we = 1'b1;
            md_a1 = ~req_op[0];
          end
          2'b11: begin
            rd_hilo = 1'b1;
            md_a1   = ~req_op[0];
          end
          default: ;
        endcase
      end
    end
  end

  assign md_mode = req_op[1:0];
  assign md_a    = rs_val;
  assign md_b    = rt_val;
  assign busy    = (state_q == StRun);

`ifdef MD_SCHED_PERF_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (req_accept) perf_ops <= perf_ops + 32'd1;
      if (stall) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: decode vector table plus multi-cycle latency sequences.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] rs_val, rt_val;
  logic        flush;
  logic        md_start, md_we, md_a1, rd_hilo, req_accept, stall, busy;
  logic [1:0]  md_mode;
  logic [31:0] md_a, md_b;
`ifdef MD_SCHED_PERF_EN
  logic [31:0] perf_ops, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  md_sched dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .flush      (flush),
    .md_start   (md_start),
    .md_mode    (md_mode),
    .md_we      (md_we),
    .md_a1      (md_a1),
    .md_a       (md_a),
    .md_b       (md_b),
    .rd_hilo    (rd_hilo),
    .req_accept (req_accept),
    .stall      (stall),
    .busy       (busy)
`ifdef MD_SCHED_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        fl;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        e_start;
    logic [1:0]  e_mode;
    logic        e_we;
    logic        e_a1;
    logic        e_rd;
    logic        e_acc;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt);
    req_valid = v;
    req_op    = op;
    rs_val    = rs;
    rt_val    = rt;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      next_cyc();
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                valid fl op    rs            rt            st mode we a1 rd acc
    vecs[0] = '{1'b1, 1'b0, 3'd0, 32'h0000_0011, 32'h0000_0022, 1, 2'd0, 0, 0, 0, 1};
    vecs[1] = '{1'b1, 1'b0, 3'd1, 32'h1234_5678, 32'h8765_4321, 1, 2'd1, 0, 0, 0, 1};
    vecs[2] = '{1'b1, 1'b0, 3'd2, 32'h0000_0064, 32'h0000_0007, 1, 2'd2, 0, 0, 0, 1};
    vecs[3] = '{1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1, 2'd3, 0, 0, 0, 1};
    vecs[4] = '{1'b1, 1'b0, 3'd4, 32'hCAFE_0001, 32'h0000_0000, 0, 2'd0, 1, 1, 0, 1};
    vecs[5] = '{1'b1, 1'b0, 3'd5, 32'hCAFE_0002, 32'h0000_0000, 0, 2'd1, 1, 0, 0, 1};
    vecs[6] = '{1'b1, 1'b0, 3'd6, 32'h0000_0000, 32'h0000_0000, 0, 2'd2, 0, 1, 1, 1};
    vecs[7] = '{1'b1, 1'b0, 3'd7, 32'h0000_0000, 32'h0000_0000, 0, 2'd3, 0, 0, 1, 1};
    vecs[8] = '{1'b1, 1'b1, 3'd0, 32'h0000_0001, 32'h0000_0002, 0, 2'd0, 0, 0, 0, 0};
    vecs[9] = '{1'b0, 1'b0, 3'd4, 32'h0000_0003, 32'h0000_0004, 0, 2'd0, 0, 0, 0, 0};

    // Reset with a request pending: strobes stay low.
    clr = 1'b1;
    flush = 1'b0;
    drive(1'b1, 3'd0, 32'd0, 32'd0);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, md_start}, 32'd0);
    check("rst_accept", {31'd0, req_accept}, 32'd0);
    next_cyc();
    next_cyc();
    clr = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    next_cyc();

    // Decode table in IDLE.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rt);
      flush = vecs[i].fl;
      @(negedge clk);
      check($sformatf("v%0d_start", i), {31'd0, md_start}, {31'd0, vecs[i].e_start});
      check($sformatf("v%0d_mode", i), {30'd0, md_mode}, {30'd0, vecs[i].e_mode});
      check($sformatf("v%0d_we", i), {31'd0, md_we}, {31'd0, vecs[i].e_we});
      check($sformatf("v%0d_a1", i), {31'd0, md_a1}, {31'd0, vecs[i].e_a1});
      check($sformatf("v%0d_rd", i), {31'd0, rd_hilo}, {31'd0, vecs[i].e_rd});
      check($sformatf("v%0d_acc", i), {31'd0, req_accept}, {31'd0, vecs[i].e_acc});
      check($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
      check($sformatf("v%0d_a", i), md_a, vecs[i].rs);
      check($sformatf("v%0d_b", i), md_b, vecs[i].rt);
      next_cyc();
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      flush = 1'b0;
      wait_idle();
    end

    // mult 3*5: busy for exactly 5 cycles after the start.
    drive(1'b1, 3'd0, 32'd3, 32'd5);
    @(negedge clk);
    check("mult_start", {31'd0, md_start}, 32'd1);
    check("mult_mode", {30'd0, md_mode}, 32'd0);
    next_cyc();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("mult_busy_t%0d", i), {31'd0, busy}, 32'd1);
      next_cyc();
    end
    @(negedge clk);
    check("mult_busy_t6", {31'd0, busy}, 32'd0);
    next_cyc();

    // div, then mflo held from T+1: stalled through T+10 (including cnt==1), taken at T+11.
    drive(1'b1, 3'd2, 32'd100, 32'd7);
    @(negedge clk);
    check("div_start", {31'd0, md_start}, 32'd1);
    next_cyc();
    drive(1'b1, 3'd7, 32'd0, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check($sformatf("div_stall_t%0d", i), {31'd0, stall}, 32'd1);
      check($sformatf("div_acc_t%0d", i), {31'd0, req_accept}, 32'd0);
      check($sformatf("div_rd_t%0d", i), {31'd0, rd_hilo}, 32'd0);
      next_cyc();
    end
    @(negedge clk);
    check("mflo_stall", {31'd0, stall}, 32'd0);
    check("mflo_acc", {31'd0, req_accept}, 32'd1);
    check("mflo_rd", {31'd0, rd_hilo}, 32'd1);
    check("mflo_a1", {31'd0, md_a1}, 32'd0);
    next_cyc();
    drive(1'b0, 3'd0, 32'd0, 32'd0);

    // mthi: one-cycle write, no state change.
    drive(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0);
    @(negedge clk);
    check("mthi_we", {31'd0, md_we}, 32'd1);
    check("mthi_a1", {31'd0, md_a1}, 32'd1);
    check("mthi_a", md_a, 32'hDEAD_BEEF);
    next_cyc();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi_we_off", {31'd0, md_we}, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    next_cyc();

    // multu, flushed divu at T+2: no stall, no strobe, multu still completes at T+6.
    drive(1'b1, 3'd1, 32'd9, 32'd9);
    @(negedge clk);
    check("multu_start", {31'd0, md_start}, 32'd1);
    next_cyc();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    next_cyc();
    drive(1'b1, 3'd3, 32'd1, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_start", {31'd0, md_start}, 32'd0);
    check("flush_acc", {31'd0, req_accept}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd1);
    next_cyc();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    flush = 1'b0;
    next_cyc();
    next_cyc();
    @(negedge clk);
    check("multu_busy_t5", {31'd0, busy}, 32'd1);
    next_cyc();
    @(negedge clk);
    check("multu_busy_t6", {31'd0, busy}, 32'd0);
    next_cyc();

    // divu, clr at T+4 drops it; mult at T+6 starts cleanly.
    drive(1'b1, 3'd3, 32'd50, 32'd0);
    @(negedge clk);
    check("divu_start", {31'd0, md_start}, 32'd1);
    next_cyc();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    next_cyc();
    next_cyc();
    next_cyc();
    check("divu_busy_t4", {31'd0, busy}, 32'd1);
    clr = 1'b1;
    drive(1'b1, 3'd0, 32'd0, 32'd0);
    #1;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_start", {31'd0, md_start}, 32'd0);
    check("clr_acc", {31'd0, req_accept}, 32'd0);
    next_cyc();
    clr = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    next_cyc();
    drive(1'b1, 3'd0, 32'd2, 32'd2);
    @(negedge clk);
    check("post_clr_start", {31'd0, md_start}, 32'd1);
    check("post_clr_stall", {31'd0, stall}, 32'd0);
    next_cyc();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    wait_idle();

`ifdef MD_SCHED_PERF_EN
    clr = 1'b1;
    next_cyc();
    clr = 1'b0;
    drive(1'b1, 3'd0, 32'd1, 32'd1);
    next_cyc();
    drive(1'b1, 3'd6, 32'd0, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("perf_stall_t%0d", i), {31'd0, stall}, 32'd1);
      next_cyc();
    end
    @(negedge clk);
    check("perf_mfhi_acc", {31'd0, req_accept}, 32'd1);
    next_cyc();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("perf_ops", perf_ops, 32'd2);
    check("perf_stall", perf_stall, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
